// File: rtl/hack_pkg.sv
// Shared constants for the 4-way 16-bit routing path: select encodings,
// default word width and the per-slot occupancy state type.
package hack_pkg;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  localparam int unsigned HACK_WORD_W = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/dmux_slot.sv
// dmux_slot: one-entry valid/ready output register with load and drain.
// Optional macro DMUX_STATS_EN adds a wrapping transfer counter (cnt).
module dmux_slot
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WORD_W
`ifdef DMUX_STATS_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] dout
`ifdef DMUX_STATS_EN
  , output logic [CNT_WIDTH-1:0] cnt
`endif
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             fire_out;

`ifdef DMUX_STATS_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`endif

  assign valid    = (state_q == SLOT_FULL);
  assign dout     = data_q;
  assign fire_out = valid & ready;

  // Next-state: a load always wins (covers refill-while-draining), else a drain empties.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = din;
    end else if (fire_out) begin
      state_d = SLOT_EMPTY;
    end
  end

`ifdef DMUX_STATS_EN
  // Counter advances once per consumer handshake and wraps naturally.
  always_comb begin
    cnt_d = cnt_q + CNT_WIDTH'(fire_out);
  end

  // Counter register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`endif

  // Slot occupancy and held word; reset discards any held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dmux4way16_router.sv
// dmux4way16_router: registered 1-to-4 demux of WIDTH-bit words with
// valid/ready on the input and an independent one-entry slot per channel.
// Optional macro DMUX_STATS_EN exposes per-channel transfer counters cnt_a..d.
module dmux4way16_router
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WORD_W
`ifdef DMUX_STATS_EN
  , parameter int unsigned CNT_WIDTH = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d
`ifdef DMUX_STATS_EN
  , output logic [CNT_WIDTH-1:0] cnt_a,
  output logic [CNT_WIDTH-1:0] cnt_b,
  output logic [CNT_WIDTH-1:0] cnt_c,
  output logic [CNT_WIDTH-1:0] cnt_d
`endif
);

  logic             fire_in;
  logic [3:0]       load;
  logic [WIDTH-1:0] slot_data [4];

`ifdef DMUX_STATS_EN
  logic [CNT_WIDTH-1:0] slot_cnt [4];
`endif

  // Selected slot can take a word if empty or draining this cycle; independent of reset.
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign fire_in  = in_valid & in_ready;

  // One-hot load decode of the destination select.
  always_comb begin
    load = '0;
    case (in_sel)
      SEL_A:   load[0] = fire_in;
      SEL_B:   load[1] = fire_in;
      SEL_C:   load[2] = fire_in;
      SEL_D:   load[3] = fire_in;
      default: load    = '0;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_slot
    dmux_slot #(
      .WIDTH     (WIDTH)
`ifdef DMUX_STATS_EN
      , .CNT_WIDTH (CNT_WIDTH)
`endif
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .din   (in_data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .dout  (slot_data[i])
`ifdef DMUX_STATS_EN
      , .cnt (slot_cnt[i])
`endif
    );
  end

  assign out_a = slot_data[0];
  assign out_b = slot_data[1];
  assign out_c = slot_data[2];
  assign out_d = slot_data[3];

`ifdef DMUX_STATS_EN
  assign cnt_a = slot_cnt[0];
  assign cnt_b = slot_cnt[1];
  assign cnt_c = slot_cnt[2];
  assign cnt_d = slot_cnt[3];
`endif

endmodule

// File: tb/tb_dmux4way16_router.sv
// Bench for dmux4way16_router: directed scenarios followed by randomized traffic,
// all checked against a per-channel occupancy/data model.
module tb_dmux4way16_router;

  localparam int unsigned W  = 16;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_sel;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic [W-1:0]  out_a, out_b, out_c, out_d;
`ifdef DMUX_STATS_EN
  logic [CW-1:0] cnt_a, cnt_b, cnt_c, cnt_d;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: is each channel holding a word, which word, how many drains.
  bit           m_full [4];
  logic [W-1:0] m_word [4];
  int unsigned  m_cnt  [4];

  always #5 clk = ~clk;

  dmux4way16_router #(
    .WIDTH     (W)
`ifdef DMUX_STATS_EN
    , .CNT_WIDTH (CW)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d)
`ifdef DMUX_STATS_EN
    , .cnt_a   (cnt_a),
    .cnt_b     (cnt_b),
    .cnt_c     (cnt_c),
    .cnt_d     (cnt_d)
`endif
  );

  function automatic logic [W-1:0] dut_word(input int unsigned i);
    case (i)
      0:       return out_a;
      1:       return out_b;
      2:       return out_c;
      default: return out_d;
    endcase
  endfunction

`ifdef DMUX_STATS_EN
  function automatic logic [CW-1:0] dut_cnt(input int unsigned i);
    case (i)
      0:       return cnt_a;
      1:       return cnt_b;
      2:       return cnt_c;
      default: return cnt_d;
    endcase
  endfunction
`endif

  // A word may enter when its destination is empty or is being consumed now.
  function automatic logic model_ready();
    return (!m_full[in_sel] || out_ready[in_sel]) ? 1'b1 : 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Check in_ready, advance one clock, update the model, check all outputs.
  task automatic step();
    bit           nf [4];
    logic [W-1:0] nw [4];
    int unsigned  nc [4];
    logic         acc;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
    acc = in_valid && model_ready();
    for (int i = 0; i < 4; i++) begin
      nf[i] = m_full[i];
      nw[i] = m_word[i];
      nc[i] = m_cnt[i];
      if (m_full[i] && out_ready[i]) begin
        nf[i] = 1'b0;
        nc[i] = (m_cnt[i] + 1) % (1 << CW);
      end
      if (acc && int'(in_sel) == i) begin
        nf[i] = 1'b1;
        nw[i] = in_data;
      end
      if (!rst_n) begin
        nf[i] = 1'b0;
        nw[i] = '0;
        nc[i] = 0;
      end
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      m_full[i] = nf[i];
      m_word[i] = nw[i];
      m_cnt[i]  = nc[i];
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("out_valid[%0d]", i), {31'd0, out_valid[i]}, {31'd0, m_full[i]});
      chk($sformatf("out_word[%0d]", i), {16'd0, dut_word(i)}, {16'd0, m_word[i]});
`ifdef DMUX_STATS_EN
      chk($sformatf("cnt[%0d]", i), 32'(dut_cnt(i)), 32'(m_cnt[i]));
`endif
    end
  endtask

  logic hold;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_word[i] = '0;
      m_cnt[i]  = 0;
    end
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    out_ready = 4'b0000;
    @(posedge clk);
    #1;

    // 1: reset held for two edges
    step();
    step();
    chk("reset_valid", {28'd0, out_valid}, 32'h0);
    chk("reset_out_a", {16'd0, out_a}, 32'h0);
    rst_n = 1'b1;

    // 2: routing with all consumers ready
    out_ready = 4'b1111;
    in_valid = 1'b1; in_data = 16'h1234; in_sel = 2'd0;
    step();
    chk("route_a", {16'd0, out_a}, 32'h1234);
    in_data = 16'hBEEF; in_sel = 2'd3;
    step();
    chk("route_d", {16'd0, out_d}, 32'hBEEF);
    in_valid = 1'b0;
    step();

    // 3: stall on channel b, then refill without a bubble
    out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 16'hAAAA; in_sel = 2'd1;
    step();
    in_data = 16'h5555;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ready", {31'd0, in_ready}, 32'h0);
      chk("stall_out_b", {16'd0, out_b}, 32'hAAAA);
    end
    out_ready = 4'b1111;
    step();
    chk("refill_b", {16'd0, out_b}, 32'h5555);
    chk("refill_valid_b", {31'd0, out_valid[1]}, 32'h1);

    // 4: isolation -- b stays full and stalled while c streams
    out_ready = 4'b1101;
    in_sel = 2'd2;
    for (int k = 1; k <= 8; k++) begin
      in_data = 16'(k);
      step();
      chk("stream_c", {16'd0, out_c}, 32'(k));
      chk("iso_out_b", {16'd0, out_b}, 32'h5555);
    end
    in_valid = 1'b0;

    // 5: reset while every channel is full
    out_ready = 4'b0000;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_sel = 2'(k); in_data = 16'hC000 + 16'(k);
      step();
    end
    in_valid = 1'b0;
    chk("all_full", {28'd0, out_valid}, 32'hF);
    rst_n = 1'b0;
    step();
    chk("midop_reset", {28'd0, out_valid}, 32'h0);
    rst_n = 1'b1;
    out_ready = 4'b1111;
    step();
    chk("post_reset_valid", {28'd0, out_valid}, 32'h0);

    // Randomized traffic honoring the producer hold rule.
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 16'($urandom);
        in_sel   = 2'($urandom_range(0, 3));
      end
      out_ready = 4'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      #1;
      hold = in_valid && !model_ready() && rst_n;
      step();
      if (!rst_n) hold = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
